// File: rtl/edge_rate_counter.sv
// edge_rate_counter: frequency meter front end. Synchronizes an external pin,
// counts its rising edges over a fixed gate window of GATE clock cycles and
// publishes the saturated per-window total together with an overflow flag.
module edge_rate_counter #(
  parameter int WIDTH = 8,
  parameter int GATE  = 12000000
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             I,
  input  logic             EN,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  output logic             OVF
);

  localparam int              GW      = $clog2(GATE);
  localparam logic [GW-1:0]   GATE_M1 = GW'(GATE - 1);
  localparam logic [WIDTH-1:0] C_MAX  = '1;

  // Saturating increment of the edge accumulator.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c,
                                               input logic             e);
    logic [WIDTH-1:0] r;
    r = c;
    if (e && (c != C_MAX)) r = c + WIDTH'(1);
    return r;
  endfunction

  // True when an increment is attempted while the accumulator is already full.
  function automatic logic sat_hit(input logic [WIDTH-1:0] c, input logic e);
    return e && (c == C_MAX);
  endfunction

  logic             s1;
  logic             s2;
  logic             p;
  logic             edge_hit;
  logic [GW-1:0]    g;
  logic             terminal;
  logic             publish;
  logic [WIDTH-1:0] c_acc;
  logic             s_flag;

  assign edge_hit = s2 & ~p;
  assign terminal = (g == '0);
  assign publish  = EN & terminal;

  // Two-flop synchronizer plus previous-sample flop, preset high so a pin that
  // is already high when reset releases is not mistaken for a rising edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      p  <= 1'b1;
    end else begin
      s1 <= I;
      s2 <= s1;
      p  <= s2;
    end
  end

  // Gate down-counter: reloads on the terminal cycle and is parked at full
  // length while disabled, so re-enabling always starts a complete window.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      g <= GATE_M1;
    end else if (!EN || terminal) begin
      g <= GATE_M1;
    end else begin
      g <= g - GW'(1);
    end
  end

  // Edge accumulator and saturation flag; both restart at every window close
  // and while disabled, so a partial window never leaks into a result.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      c_acc  <= '0;
      s_flag <= 1'b0;
    end else if (!EN || terminal) begin
      c_acc  <= '0;
      s_flag <= 1'b0;
    end else begin
      c_acc <= sat_inc(c_acc, edge_hit);
      if (sat_hit(c_acc, edge_hit)) s_flag <= 1'b1;
    end
  end

  // Published result: the terminal-cycle edge still belongs to the closing
  // window, so it is folded in here rather than into the next accumulation.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      O     <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else begin
      VALID <= publish;
      if (publish) begin
        O   <= sat_inc(c_acc, edge_hit);
        OVF <= s_flag | sat_hit(c_acc, edge_hit);
      end
    end
  end

endmodule
